// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage with a prefetch queue: issues sequential fetches ahead of decode,
// tolerates in-order variable-latency memory responses and discards stale fetches on branches.
module fetch_queue_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] pc
);

  localparam int unsigned  PtrW   = $clog2(DEPTH);
  localparam int unsigned  CntW   = $clog2(DEPTH + 1);
  localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]   occ_q, occ_d;
  logic [CntW-1:0]   inflight_q, inflight_d;
  logic [CntW-1:0]   drop_q, drop_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   aq_wr_q, aq_wr_d;
  logic [PtrW-1:0]   aq_rd_q, aq_rd_d;

  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  // Addresses of accepted requests, consumed in order by every response (kept or dropped).
  logic [ADDR_W-1:0] aq_addr_q   [DEPTH];

  logic req_fire, rsp_drop, push, pop, head_valid;

  always_comb begin
    imem_req_valid = ~rst & (({1'b0, occ_q} + {1'b0, inflight_q}) < DepthC);
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid & imem_req_ready;
    rsp_drop       = imem_rsp_valid & (drop_q != '0);
    push           = imem_rsp_valid & ~rsp_drop & ~branch_taken;
    head_valid     = ~rst & (occ_q != '0);
    pop            = head_valid & ~freeze & ~branch_taken;

    inflight_d = inflight_q + CntW'(req_fire) - CntW'(imem_rsp_valid);
    aq_wr_d    = aq_wr_q + PtrW'(req_fire);
    aq_rd_d    = aq_rd_q + PtrW'(imem_rsp_valid);

    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    occ_d      = occ_q + CntW'(push) - CntW'(pop);
    wr_ptr_d   = wr_ptr_q + PtrW'(push);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
    if (rsp_drop) begin
      drop_d = drop_q - CntW'(1);
    end
    // Redirect: everything still outstanding after this cycle becomes stale.
    if (branch_taken) begin
      fetch_pc_d = branch_addr;
      drop_d     = inflight_d;
      occ_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end

    inst_valid  = head_valid;
    instruction = head_valid ? fifo_data_q[rd_ptr_q] : '0;
    pc          = head_valid ? fifo_addr_q[rd_ptr_q] + PC_STEP : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      occ_q      <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      aq_wr_q    <= '0;
      aq_rd_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      aq_wr_q    <= aq_wr_d;
      aq_rd_q    <= aq_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      aq_addr_q[aq_wr_q] <= fetch_pc_q;
    end
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= aq_addr_q[aq_rd_q];
      fifo_data_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage with an in-order fixed-latency memory model.
module tb_fetch_queue_stage;

  localparam logic [31:0] Off = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [31:0] pc;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t mq[$];
  int   cyc = 0;
  int   lat = 1;
  int   nchk = 0;
  int   nerr = 0;

  fetch_queue_stage #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .DEPTH   (4),
    .RESET_PC(32'h0),
    .PC_STEP (32'h4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .branch_taken  (branch_taken),
    .branch_addr   (branch_addr),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .instruction   (instruction),
    .pc            (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Records the current cycle's accepted request, advances one edge, then drives the
  // memory response due in the new cycle.
  task automatic step();
    req_t r;
    #1;
    if (rst) begin
      mq.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      r.addr = imem_req_addr;
      r.due  = cyc + lat;
      mq.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!rst && mq.size() > 0 && mq[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].addr + Off;
      void'(mq.pop_front());
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Leaves the bench in cycle 1: first cycle with rst low.
  task automatic do_reset();
    rst = 1'b1;
    freeze = 1'b0;
    branch_taken = 1'b0;
    imem_req_ready = 1'b1;
    run(2);
    rst = 1'b0;
    cyc = 1;
    #1;
  endtask

  initial begin
    // Startup stream, L=1, then branch with simultaneous req_fire and response.
    lat = 1;
    do_reset();
    chk("c1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("c1_req_addr", imem_req_addr, 32'h0);
    chk("c1_inst_valid", 32'(inst_valid), 32'd0);
    chk("c1_instr_zero", instruction, 32'h0);
    step();
    chk("c2_inst_valid", 32'(inst_valid), 32'd0);
    chk("c2_req_addr", imem_req_addr, 32'h4);
    step();
    chk("c3_inst_valid", 32'(inst_valid), 32'd1);
    chk("c3_pc", pc, 32'h4);
    chk("c3_instr", instruction, Off + 32'h0);
    step();
    chk("c4_pc", pc, 32'h8);
    chk("c4_instr", instruction, Off + 32'h4);
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    step();
    branch_taken = 1'b0;
    chk("br1_n1_inst_valid", 32'(inst_valid), 32'd0);
    chk("br1_n1_req_addr", imem_req_addr, 32'h200);
    chk("br1_n1_req_valid", 32'(imem_req_valid), 32'd1);
    step();
    chk("br1_n2_inst_valid", 32'(inst_valid), 32'd0);
    step();
    chk("br1_target_pc", pc, 32'h204);
    chk("br1_target_instr", instruction, Off + 32'h200);
    step();
    chk("br1_next_pc", pc, 32'h208);

    // Freeze for cycles 1..10: queue fills, then drains back-to-back.
    lat = 1;
    do_reset();
    freeze = 1'b1;
    run(3);
    chk("frz_c4_req_valid", 32'(imem_req_valid), 32'd1);
    chk("frz_c4_pc", pc, 32'h4);
    step();
    chk("frz_c5_req_valid", 32'(imem_req_valid), 32'd0);
    run(5);
    chk("frz_c10_req_valid", 32'(imem_req_valid), 32'd0);
    chk("frz_c10_pc", pc, 32'h4);
    chk("frz_c10_instr", instruction, Off + 32'h0);
    step();
    freeze = 1'b0;
    chk("frz_c11_pc", pc, 32'h4);
    chk("frz_c11_req_valid", 32'(imem_req_valid), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("frz_drain_valid", 32'(inst_valid), 32'd1);
      chk("frz_drain_pc", pc, 32'(4 + 4 * k));
    end

    // L=3: branch in cycle 3 with three requests outstanding.
    lat = 3;
    do_reset();
    run(2);
    chk("br3_c3_inst_valid", 32'(inst_valid), 32'd0);
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    step();
    branch_taken = 1'b0;
    chk("br3_c4_req_addr", imem_req_addr, 32'h100);
    chk("br3_c4_inst_valid", 32'(inst_valid), 32'd0);
    for (int k = 5; k <= 7; k++) begin
      step();
      chk("br3_stale_hidden", 32'(inst_valid), 32'd0);
    end
    step();
    chk("br3_c8_pc", pc, 32'h104);
    chk("br3_c8_instr", instruction, Off + 32'h100);
    step();
    chk("br3_c9_pc", pc, 32'h108);

    // Ready pattern 1,0,0,1 across cycles 1..4.
    lat = 1;
    do_reset();
    step();
    imem_req_ready = 1'b0;
    chk("rdy_c2_addr", imem_req_addr, 32'h4);
    chk("rdy_c2_valid", 32'(imem_req_valid), 32'd1);
    step();
    chk("rdy_c3_addr", imem_req_addr, 32'h4);
    chk("rdy_c3_pc", pc, 32'h4);
    step();
    imem_req_ready = 1'b1;
    chk("rdy_c4_addr", imem_req_addr, 32'h4);
    chk("rdy_c4_inst_valid", 32'(inst_valid), 32'd0);
    step();
    chk("rdy_c5_addr", imem_req_addr, 32'h8);
    chk("rdy_c5_inst_valid", 32'(inst_valid), 32'd0);
    step();
    chk("rdy_c6_pc", pc, 32'h8);
    step();
    chk("rdy_c7_pc", pc, 32'hc);

    // Reset mid-operation with occ=3, inflight=1.
    lat = 1;
    do_reset();
    freeze = 1'b1;
    run(4);
    chk("rst_pre_pc", pc, 32'h4);
    rst = 1'b1;
    #1;
    chk("rst_during_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_during_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_during_pc", pc, 32'h0);
    step();
    rst = 1'b0;
    freeze = 1'b0;
    cyc = 1;
    #1;
    chk("rst_after_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_after_pc", pc, 32'h0);
    chk("rst_after_instr", instruction, 32'h0);
    chk("rst_after_req_addr", imem_req_addr, 32'h0);
    chk("rst_after_req_valid", 32'(imem_req_valid), 32'd1);
    run(2);
    chk("rst_restart_pc", pc, 32'h4);
    chk("rst_restart_instr", instruction, Off + 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
